// File: rtl/plot_pixel_buffer.sv
// Clips drawer pixels to the screen, queues them in a FIFO and drains them to the
// framebuffer over valid/ready. Optional full-screen clear is enabled by PLOT_CLEAR_EN.
module plot_pixel_buffer #(
    parameter int DEPTH = 16,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_colour,
    output logic        fb_we,
    input  logic        fb_ready,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
`ifdef PLOT_CLEAR_EN
    input  logic        clear,
    input  logic [2:0]  clear_colour,
`endif
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    X_LIM    = 8'(SCR_W);
    localparam logic [6:0]    Y_LIM    = 7'(SCR_H);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_idx;
    logic [CW-1:0] r_count, w_count_nxt, w_avail;
    logic          w_in_range, w_push_try, w_push, w_pop, w_lost;
    logic [14:0]   w_addr;
    state_t        r_state, w_state_nxt;
    logic          r_fb_we, r_ovf;
    logic [14:0]   r_fb_addr;
    logic [2:0]    r_fb_colour;
    logic [7:0]    r_drop;
    logic          w_clr_start, w_clr_done;
    logic [2:0]    w_clr_colour;

    assign w_in_range = (vga_x < X_LIM) && (vga_y < Y_LIM);
    assign w_push_try = vga_plot && w_in_range;
    assign w_pop      = r_fb_we && fb_ready && (r_state != S_CLEAR);
    // A full FIFO still takes a pixel when its head leaves on the same edge.
    assign w_push     = w_push_try && ((r_count != FULL_CNT) || w_pop);
    assign w_lost     = vga_plot && !w_push;
    assign w_addr     = ({8'b0, vga_y} << 7) + ({8'b0, vga_y} << 5) + {7'b0, vga_x};

    // Entries already resident in memory after this edge's pop; a same-edge push is not readable yet.
    assign w_avail  = r_count - CW'(w_pop);
    assign w_rd_idx = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

`ifdef PLOT_CLEAR_EN
    localparam logic [14:0] LAST_ADDR = 15'(SCR_W * SCR_H - 1);
    logic r_clr_pend;

    assign w_clr_start  = (r_state == S_IDLE) && (clear || r_clr_pend);
    assign w_clr_done   = (r_state == S_CLEAR) && fb_ready && (r_fb_addr == LAST_ADDR);
    assign w_clr_colour = clear_colour;

    always_ff @(posedge clk) begin
        if (rstn)
            r_clr_pend <= 1'b0;
        else if (r_state == S_DRAIN && clear)
            r_clr_pend <= 1'b1;
        else if (w_clr_start)
            r_clr_pend <= 1'b0;
    end
`else
    assign w_clr_start  = 1'b0;
    assign w_clr_done   = 1'b0;
    assign w_clr_colour = 3'b000;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_clr_start) w_state_nxt = S_CLEAR;
                     else if (w_count_nxt != '0) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_IDLE;
            S_CLEAR: if (w_clr_done) w_state_nxt = (w_count_nxt != '0) ? S_DRAIN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn && w_push)
            r_mem[r_wr_ptr] <= {w_addr, vga_colour};
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= 8'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            if (w_push_try && !w_push) r_ovf <= 1'b1;
            if (w_lost && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    // Output stage: the clear sweep reuses r_fb_addr as its address counter.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_fb_we     <= 1'b0;
            r_fb_addr   <= 15'd0;
            r_fb_colour <= 3'd0;
        end else if (w_clr_start) begin
            r_fb_we     <= 1'b1;
            r_fb_addr   <= 15'd0;
            r_fb_colour <= w_clr_colour;
        end else if (r_state == S_CLEAR && !w_clr_done) begin
            if (fb_ready) r_fb_addr <= r_fb_addr + 15'd1;
        end else if (r_fb_we && !fb_ready) begin
            r_fb_we <= 1'b1;
        end else if (w_avail != '0) begin
            r_fb_we                  <= 1'b1;
            {r_fb_addr, r_fb_colour} <= r_mem[w_rd_idx];
        end else begin
            r_fb_we <= 1'b0;
        end
    end

    assign fb_we     = r_fb_we;
    assign fb_addr   = r_fb_addr;
    assign fb_colour = r_fb_colour;
    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign overflow  = r_ovf;
    assign drop_cnt  = r_drop;
    assign busy      = (r_count != '0) || (r_state == S_CLEAR);

endmodule

// File: doc/plot_pixel_buffer.md
Name: plot_pixel_buffer

Overview:
- Sits directly downstream of the circle-drawing engine.
- Accepts its per-pixel plot strobes (vga_x, vga_y, vga_colour, vga_plot) and clips off-screen pixels.
- Buffers accepted pixels in a small FIFO and drains them to the 160x120 framebuffer write port using a valid/ready handshake.
- Decouples the drawer's one-pixel-per-clock output from a framebuffer that may stall.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- SCR_W, 160, screen width in pixels.
- SCR_H, 120, screen height in pixels.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  synchronous, active-high reset (asserted = 1)
- vga_x  input  8  pixel x from the drawer
- vga_y  input  7  pixel y from the drawer
- vga_colour  input  3  pixel colour
- vga_plot  input  1  pixel valid strobe; one pixel per cycle when high
- fb_addr  output  15  framebuffer word address, y*SCR_W + x
- fb_colour  output  3  framebuffer write data
- fb_we  output  1  write valid
- fb_ready  input  1  framebuffer accepts the write this cycle
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- overflow  output  1  sticky: an in-range pixel was lost because the FIFO was full
- drop_cnt  output  8  count of clipped plus overflowed pixels, saturating at 255
- busy  output  1  high while the FIFO is non-empty or a clear is running

Behaviour:
- Reset: evaluated on clk while rstn = 1, and has priority over all other activity.
  - Outputs after reset: fb_we = 0, fb_addr = 0, fb_colour = 0, full = 0, empty = 1, overflow = 0, drop_cnt = 0, busy = 0.
  - Pointers and occupancy count clear; FIFO contents are discarded.
  - Reset asserted mid-drain or mid-clear aborts immediately; fb_we is 0 from the next cycle.
- Clipping:
  - A pixel is in range when vga_x < SCR_W and vga_y < SCR_H.
  - An out-of-range pixel with vga_plot = 1 is not stored and increments drop_cnt.
- Push: on a cycle with vga_plot = 1 and the pixel in range.
  - Pixel is written if count < DEPTH, or if count = DEPTH and a pop occurs in the same cycle.
  - Otherwise it is lost: overflow is set (sticky until reset) and drop_cnt increments.
- Address: computed at push time as (y<<7) + (y<<5) + x in 15 bits and stored with the colour.
  - Maximum value is 19199.
- Pop and handshake:
  - fb_we, fb_addr and fb_colour are registered and present the FIFO head, first-word fall-through.
  - A write completes on a cycle with fb_we = 1 and fb_ready = 1; the next entry, if any, is presented the following cycle.
  - While fb_we = 1 and fb_ready = 0, fb_addr and fb_colour hold stable.
- Latency: a pixel pushed into an empty FIFO at edge N appears with fb_we = 1 after edge N+1.
  - Sustained throughput is one pixel per cycle when fb_ready stays high.
- Occupancy: count is updated +1, -1 or 0 per cycle.
  - A simultaneous push and pop leaves count unchanged.
  - full and empty are decoded from the registered count.
- Pointers: wrap modulo DEPTH.
- drop_cnt: increments by at most 1 per cycle and holds at 255.
- States: IDLE (empty, fb_we = 0) -> DRAIN on a non-empty FIFO; DRAIN -> IDLE when the last entry completes with no push pending. With the optional feature, CLEAR is added.

Optional Feature:
- Macro: PLOT_CLEAR_EN.
- Defined:
  - Adds inputs clear (1 bit, single-cycle pulse) and clear_colour (3 bits).
  - A clear pulse seen in IDLE enters CLEAR and writes clear_colour to addresses 0..19199 in ascending order.
  - Each address advances only on fb_ready; fb_we is held high throughout.
  - Pushes are still accepted into the FIFO during CLEAR and drain after the clear finishes (CLEAR -> DRAIN or IDLE).
  - A clear pulse in DRAIN is latched and starts once the FIFO empties.
  - A clear pulse during CLEAR is ignored.
  - busy is high throughout CLEAR.
- Undefined: no clear or clear_colour ports, and no CLEAR state.

Test Plan:
- Single pixel: reset, then push x=10, y=5, colour=3'b101 with fb_ready=1 -> one cycle of fb_we=1 with fb_addr=810, fb_colour=5; then empty=1 and busy=0.
- Back-pressure: hold fb_ready=0 and push 16 pixels -> full=1; a 17th push -> overflow=1, drop_cnt=1. Release fb_ready -> exactly 16 writes in push order.
- Clipping: push x=160 and y=120, then x=159, y=119 -> drop_cnt=2 and one write to fb_addr=19199.
- Full with simultaneous push/pop: fill to 16, then fb_ready=1 with a push on the same cycle -> count stays 16, overflow stays 0.
- Mid-operation reset: 8 entries queued, fb_ready=0, assert rstn for 1 cycle -> fb_we=0, empty=1, drop_cnt=0, and no further writes.
- PLOT_CLEAR_EN: clear with clear_colour=3'b000 and fb_ready=1 -> 19200 writes, addresses 0..19199, busy high for 19200 cycles. A pixel pushed mid-clear is written after address 19199.
